dau_display_sink: RTL

//  Consumer end of the DAU output symbol stream (o_symbol/o_symbol_valid, no backpressure).

---
 rtl/dau_display_sink_pkg.sv | 44 ++++
 rtl/dau_seg_encode.sv | 32 +++
 rtl/dau_display_sink.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/dau_display_sink_pkg.sv
// Shared definitions for the DAU display sink.
// Holds the DAU symbol codes, the active-low 7-segment glyph patterns and the FSM state types.
package dau_display_sink_pkg;

   localparam int unsigned DAU_SYM_WIDTH = 5;
   localparam int unsigned SEG_WIDTH     = 8;

   typedef logic [DAU_SYM_WIDTH-1:0] dau_sym_t;
   typedef logic [SEG_WIDTH-1:0]     seg_t;

   // DAU output symbol codes; every other code is an echo the sink ignores
   localparam dau_sym_t DAU_SYM_0     = 5'd0;
   localparam dau_sym_t DAU_SYM_1     = 5'd1;
   localparam dau_sym_t DAU_SYM_2     = 5'd2;
   localparam dau_sym_t DAU_SYM_3     = 5'd3;
   localparam dau_sym_t DAU_SYM_4     = 5'd4;
   localparam dau_sym_t DAU_SYM_5     = 5'd5;
   localparam dau_sym_t DAU_SYM_6     = 5'd6;
   localparam dau_sym_t DAU_SYM_7     = 5'd7;
   localparam dau_sym_t DAU_SYM_8     = 5'd8;
   localparam dau_sym_t DAU_SYM_9     = 5'd9;
   localparam dau_sym_t DAU_SYM_MINUS = 5'd10;
   localparam dau_sym_t DAU_SYM_COMMA = 5'd11;
   localparam dau_sym_t DAU_SYM_EOL   = 5'd12;

   // Segment patterns {dp,g,f,e,d,c,b,a}, active-low
   localparam seg_t SEG_0       = 8'hC0;
   localparam seg_t SEG_1       = 8'hF9;
   localparam seg_t SEG_2       = 8'hA4;
   localparam seg_t SEG_3       = 8'hB0;
   localparam seg_t SEG_4       = 8'h99;
   localparam seg_t SEG_5       = 8'h92;
   localparam seg_t SEG_6       = 8'h82;
   localparam seg_t SEG_7       = 8'hF8;
   localparam seg_t SEG_8       = 8'h80;
   localparam seg_t SEG_9       = 8'h90;
   localparam seg_t SEG_MINUS   = 8'hBF;
   localparam seg_t SEG_BLANK   = 8'hFF;
   localparam seg_t SEG_DP_MASK = 8'h7F;  // AND-mask that lights the decimal point

   typedef enum logic {RX_IDLE, RX_COLLECT} rx_state_e;
   typedef enum logic {SCAN_ON, SCAN_BLANK} scan_state_e;

endpackage

// File: rtl/dau_seg_encode.sv
// Combinational DAU symbol to 7-segment glyph encoder.
// Ports: sym (DAU symbol code), seg_c (active-low pattern, blank for non-glyphs),
//        is_glyph_c (symbol is a digit or minus sign).
module dau_seg_encode
   import dau_display_sink_pkg::*;
(
   input  logic [DAU_SYM_WIDTH-1:0] sym,
   output logic [SEG_WIDTH-1:0]     seg_c,
   output logic                     is_glyph_c
);

   // Glyph lookup
   always_comb begin
      seg_c      = SEG_BLANK;
      is_glyph_c = 1'b1;
      case (sym)
         DAU_SYM_0:     seg_c = SEG_0;
         DAU_SYM_1:     seg_c = SEG_1;
         DAU_SYM_2:     seg_c = SEG_2;
         DAU_SYM_3:     seg_c = SEG_3;
         DAU_SYM_4:     seg_c = SEG_4;
         DAU_SYM_5:     seg_c = SEG_5;
         DAU_SYM_6:     seg_c = SEG_6;
         DAU_SYM_7:     seg_c = SEG_7;
         DAU_SYM_8:     seg_c = SEG_8;
         DAU_SYM_9:     seg_c = SEG_9;
         DAU_SYM_MINUS: seg_c = SEG_MINUS;
         default:       is_glyph_c = 1'b0;
      endcase
   end

endmodule

// File: rtl/dau_display_sink.sv
// Consumer end of the DAU symbol stream.
// Builds each printed number right-aligned in a shadow frame, commits it to the active frame on
// end-of-line and scans the active frame onto a multiplexed common-anode 7-segment display.
// Ports: i_clk, i_rst (sync, active-high), i_symbol/i_symbol_valid (stream, no backpressure),
//        o_seg (active-low segments), o_an (active-low anodes), o_frame_valid (commit pulse),
//        o_overflow (last committed frame had more glyphs than positions).
module dau_display_sink
   import dau_display_sink_pkg::*;
#(
   parameter int unsigned NUM_CHARS    = 8,
   parameter int unsigned SCAN_DIV     = 50000,
   parameter int unsigned BLANK_CYCLES = 64
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic [DAU_SYM_WIDTH-1:0] i_symbol,
   input  logic                     i_symbol_valid,
   output logic [SEG_WIDTH-1:0]     o_seg,
   output logic [NUM_CHARS-1:0]     o_an,
   output logic                     o_frame_valid,
   output logic                     o_overflow
);

   localparam int unsigned CNT_W  = $clog2(NUM_CHARS + 1);
   localparam int unsigned IDX_W  = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;
   localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   typedef logic [NUM_CHARS-1:0][SEG_WIDTH-1:0] frame_t;

   logic [SEG_WIDTH-1:0] glyph_c;
   logic                 is_glyph_c;

   rx_state_e            rx_state_q, rx_state_d;
   frame_t               shadow_q, shadow_d;
   frame_t               active_q;
   logic [CNT_W-1:0]     count_q, count_d;
   logic                 pend_q, pend_d;
   logic                 commit_c;

   scan_state_e          scan_state_q, scan_state_d;
   logic [SCAN_W-1:0]    scan_cnt_q, scan_cnt_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [SEG_WIDTH-1:0] seg_d;
   logic [NUM_CHARS-1:0] an_d;

   dau_seg_encode u_encode (
      .sym        (i_symbol),
      .seg_c      (glyph_c),
      .is_glyph_c (is_glyph_c)
   );

   // Receiver next state: shift glyphs in, apply decimal point, commit on EOL
   always_comb begin
      rx_state_d = rx_state_q;
      shadow_d   = shadow_q;
      count_d    = count_q;
      pend_d     = pend_q;
      commit_c   = 1'b0;
      if (i_symbol_valid) begin
         if (i_symbol == DAU_SYM_EOL) begin
            rx_state_d = RX_IDLE;
            commit_c   = 1'b1;
            shadow_d   = '1;
            count_d    = '0;
            pend_d     = 1'b0;
         end else if (is_glyph_c) begin
            rx_state_d = RX_COLLECT;
            if (count_q == CNT_W'(NUM_CHARS)) begin
               pend_d = 1'b1;
            end else begin
               shadow_d    = shadow_q << SEG_WIDTH;
               shadow_d[0] = glyph_c;
               count_d     = count_q + CNT_W'(1);
            end
         end else if (i_symbol == DAU_SYM_COMMA) begin
            rx_state_d = RX_COLLECT;
            // A leading comma implies a zero integer part
            if (count_q == '0) begin
               shadow_d    = shadow_q << SEG_WIDTH;
               shadow_d[0] = SEG_0 & SEG_DP_MASK;
               count_d     = CNT_W'(1);
            end else begin
               shadow_d[0] = shadow_q[0] & SEG_DP_MASK;
            end
         end
      end
   end

   // Receiver registers and committed outputs
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rx_state_q    <= RX_IDLE;
         shadow_q      <= '1;
         active_q      <= '1;
         count_q       <= '0;
         pend_q        <= 1'b0;
         o_frame_valid <= 1'b0;
         o_overflow    <= 1'b0;
      end else begin
         rx_state_q    <= rx_state_d;
         shadow_q      <= shadow_d;
         count_q       <= count_d;
         pend_q        <= pend_d;
         o_frame_valid <= commit_c;
         if (commit_c) begin
            active_q   <= shadow_q;
            o_overflow <= pend_q;
         end
      end
   end

   // Scanner next state: light one position, then blank before moving on
   always_comb begin
      scan_state_d = scan_state_q;
      scan_cnt_d   = scan_cnt_q + SCAN_W'(1);
      idx_d        = idx_q;
      an_d         = '1;
      seg_d        = SEG_BLANK;
      case (scan_state_q)
         SCAN_ON: begin
            an_d[idx_q] = 1'b0;
            seg_d       = active_q[idx_q];
            if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
               scan_state_d = SCAN_BLANK;
               scan_cnt_d   = '0;
            end
         end
         SCAN_BLANK: begin
            if (scan_cnt_q == SCAN_W'(BLANK_CYCLES - 1)) begin
               scan_state_d = SCAN_ON;
               scan_cnt_d   = '0;
               idx_d        = (idx_q == IDX_W'(NUM_CHARS - 1)) ? '0 : idx_q + IDX_W'(1);
            end
         end
         default: begin
            scan_state_d = SCAN_ON;
            scan_cnt_d   = '0;
         end
      endcase
   end

   // Scanner registers and display outputs
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         scan_state_q <= SCAN_ON;
         scan_cnt_q   <= '0;
         idx_q        <= '0;
         o_seg        <= SEG_BLANK;
         o_an         <= '1;
      end else begin
         scan_state_q <= scan_state_d;
         scan_cnt_q   <= scan_cnt_d;
         idx_q        <= idx_d;
         o_seg        <= seg_d;
         o_an         <= an_d;
      end
   end

endmodule
